// File: rtl/clkdiv_gen.sv
// rtl/clkdiv_gen.sv - multi-channel programmable clock divider with lock tracking
//
// Purpose:
//   NUM_CH independent divide-by-D counters. Each channel produces a one-cycle
//   enable strobe and a ~50% duty square wave. Ratios are reprogrammed through
//   a single-entry request slot. A new ratio only takes effect on the target
//   channel's wrap edge, so no clk_out phase is cut short. A lock FSM reports
//   when every channel has settled after reset or after a ratio change.
//
// Ports:
//   clk        sole clock, all state updates on the rising edge
//   rst        synchronous active-high reset, priority over everything
//   cfg_valid  reconfiguration request
//   cfg_ready  request slot empty, a request can be accepted
//   cfg_ch     target channel; values >= NUM_CH are accepted and dropped
//   cfg_div    new divide ratio D (0 disables the channel)
//   cfg_phase  counter start value after the update (0 if >= cfg_div)
//   en_out     per-channel enable strobe at cnt==D-1, qualified by locked
//   clk_out    per-channel divided square wave, high while cnt < (D+1)/2
//   locked     all channels running at their configured ratio

module clkdiv_gen #(
  parameter int  NUM_CH      = 2,
  parameter int  DIV_W       = 16,
  parameter int  DEFAULT_DIV = 6,
  parameter int  LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] en_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int               LK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W:0]   HALF_RND = (DIV_W + 1)'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [LK_W-1:0]  LK_ONE  = LK_W'(1);
  localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    S_LOCKING = 1'b0,
    S_LOCKED  = 1'b1
  } lock_state_t;

  // Per-channel ratio and counter.
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];

  // Single-entry request slot.
  logic              pend_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [DIV_W-1:0]  pend_div_q;
  logic [DIV_W-1:0]  pend_phase_q;

  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] ch_match;
  logic [NUM_CH-1:0] apply_hit;
  logic              apply_any;
  logic              pend_drop;
  logic              accept;
  logic [DIV_W-1:0]  load_cnt;

  lock_state_t       state_q;
  lock_state_t       state_d;
  logic [LK_W-1:0]   lock_cnt_q;

  // ---------------------------------------------------------------------------
  // Request slot
  // ---------------------------------------------------------------------------
  assign cfg_ready = !pend_q;
  assign accept    = cfg_valid && cfg_ready;

  // A disabled channel has no wrap edge to wait for, so it takes the
  // update on the first edge after acceptance.
  always_comb begin
    wrap      = '0;
    ch_match  = '0;
    apply_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]      = (div_q[i] != '0) && (cnt_q[i] == div_q[i] - DIV_ONE);
      ch_match[i]  = (pend_ch_q == CH_W'(i));
      apply_hit[i] = pend_q && ch_match[i] && (wrap[i] || (div_q[i] == '0));
    end
  end

  assign apply_any = |apply_hit;
  // Out-of-range channel: no channel matches, so the slot empties after one cycle.
  assign pend_drop = pend_q && (ch_match == '0);
  assign load_cnt  = (pend_phase_q >= pend_div_q) ? '0 : pend_phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
    end else if (accept) begin
      pend_q       <= 1'b1;
      pend_ch_q    <= cfg_ch;
      pend_div_q   <= cfg_div;
      pend_phase_q <= cfg_phase;
    end else if (apply_any || pend_drop) begin
      pend_q       <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        div_q[i] <= DIV_RST;
        cnt_q[i] <= '0;
      end else if (apply_hit[i]) begin
        div_q[i] <= pend_div_q;
        cnt_q[i] <= load_cnt;
      end else if ((div_q[i] == '0) || wrap[i]) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_q[i] + DIV_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOCKING;
    end else begin
      state_q <= state_d;
    end
  end

  // Any ratio change, including one landing mid-lock, restarts the settle time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOCKING: if (lock_cnt_q == LK_LAST) state_d = S_LOCKED;
      S_LOCKED:  state_d = S_LOCKED;
      default:   state_d = S_LOCKING;
    endcase
    if (apply_any) state_d = S_LOCKING;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q <= '0;
    end else if (apply_any) begin
      lock_cnt_q <= '0;
    end else if (state_q == S_LOCKING) begin
      lock_cnt_q <= lock_cnt_q + LK_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    locked  = (state_q == S_LOCKED);
    en_out  = '0;
    clk_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      en_out[i]  = locked && wrap[i];
      // Widened by one bit so (D+1) cannot overflow at D = 2**DIV_W-1.
      clk_out[i] = ({1'b0, cnt_q[i]} < (({1'b0, div_q[i]} + HALF_RND) >> 1));
    end
  end

endmodule

// File: tb/tb_clkdiv_gen.sv
// tb/tb_clkdiv_gen.sv - self-checking bench for clkdiv_gen

module tb_clkdiv_gen;

  localparam int NCH  = 3;
  localparam int DW   = 16;
  localparam int DEFD = 6;
  localparam int LCK  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [DW-1:0]  cfg_phase;
  logic [NCH-1:0] en_out;
  logic [NCH-1:0] clk_out;
  logic           locked;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clkdiv_gen #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (DEFD),
    .LOCK_CYCLES (LCK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .en_out    (en_out),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  // Behavioural model: each channel is a ratio plus the edge at which its
  // counter was last (re)started and the start value; the counter value at any
  // edge follows by modular arithmetic. Lock is "LCK edges since last restart".
  longint cyc    = 0;
  bit     mvalid = 1'b0;
  int     m_div  [NCH];
  longint m_base [NCH];
  int     m_bval [NCH];
  bit     m_pend = 1'b0;
  int     p_ch, p_div, p_phase;
  longint p_edge;
  longint m_lock_edge;

  function automatic int m_cnt(int ch, longint n);
    if (m_div[ch] == 0) return 0;
    return int'((longint'(m_bval[ch]) + (n - m_base[ch])) % longint'(m_div[ch]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c]  = DEFD;
        m_base[c] = cyc;
        m_bval[c] = 0;
      end
      m_pend      = 1'b0;
      m_lock_edge = cyc;
      mvalid      = 1'b1;
    end else if (mvalid) begin
      if (m_pend) begin
        if (cyc == p_edge) begin
          if (p_ch < NCH) begin
            m_div[p_ch]  = p_div;
            m_base[p_ch] = cyc;
            m_bval[p_ch] = (p_phase >= p_div) ? 0 : p_phase;
            m_lock_edge  = cyc;
          end
          m_pend = 1'b0;
        end
      end else if (cfg_valid) begin
        m_pend  = 1'b1;
        p_ch    = int'(cfg_ch);
        p_div   = int'(cfg_div);
        p_phase = int'(cfg_phase);
        if (p_ch >= NCH) p_edge = cyc + 1;
        else if (m_div[p_ch] == 0) p_edge = cyc + 1;
        else p_edge = cyc + 1 + longint'(m_div[p_ch] - 1 - m_cnt(p_ch, cyc));
      end
    end
  end

  bit e_lock;
  int e_c, e_d;

  always @(negedge clk) begin
    if (mvalid) begin
      e_lock = (cyc - m_lock_edge) >= LCK;
      chk("locked", {31'b0, locked}, {31'b0, e_lock});
      chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_pend});
      for (int c = 0; c < NCH; c++) begin
        e_c = m_cnt(c, cyc);
        e_d = m_div[c];
        chk($sformatf("en_out[%0d]", c), {31'b0, en_out[c]},
            {31'b0, (e_lock && e_d > 0 && e_c == e_d - 1)});
        chk($sformatf("clk_out[%0d]", c), {31'b0, clk_out[c]},
            {31'b0, (e_c < (e_d + 1) / 2)});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input int ch, input int dv, input int ph);
    bit took;
    took      = 1'b0;
    cfg_ch    = 2'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    cfg_valid = 1'b1;
    for (int k = 0; k < 200 && !took; k++) begin
      took = cfg_ready;
      tick(1);
    end
    cfg_valid = 1'b0;
    chk("write_accepted", {31'b0, took}, 32'd1);
  endtask

  task automatic wait_ready(input int bound);
    for (int k = 0; k < bound && !cfg_ready; k++) tick(1);
    chk("wait_ready", {31'b0, cfg_ready}, 32'd1);
  endtask

  task automatic wait_locked(input int bound);
    for (int k = 0; k < bound && !locked; k++) tick(1);
    chk("wait_locked", {31'b0, locked}, 32'd1);
  endtask

  initial begin
    int n, hi, k;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;

    tick(3);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_clk_out", {29'b0, clk_out}, 32'd7);
    chk("rst_en_out", {29'b0, en_out}, 32'd0);
    rst = 1'b0;

    tick(15);
    chk("locked_edge15", {31'b0, locked}, 32'd0);
    tick(1);
    chk("locked_edge16", {31'b0, locked}, 32'd1);

    n = 0; hi = 0;
    for (int i = 0; i < 12; i++) begin
      n  += int'(en_out[0]);
      hi += int'(clk_out[1]);
      tick(1);
    end
    chk("en0_pulses_12cyc", n, 32'd2);
    chk("clk1_high_12cyc", hi, 32'd6);

    write(0, 4, 0);
    chk("ready_low_after_accept", {31'b0, cfg_ready}, 32'd0);
    wait_ready(20);
    chk("locked_low_after_apply", {31'b0, locked}, 32'd0);
    hi = 0; n = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(clk_out[0]);
      n  += int'(en_out[0]);
      tick(1);
    end
    chk("clk0_high_8cyc_div4", hi, 32'd4);
    chk("en0_none_while_locking", n, 32'd0);
    wait_locked(40);

    write(1, 0, 0);
    wait_ready(20);
    tick(2);
    chk("ch1_disabled_clk", {31'b0, clk_out[1]}, 32'd0);
    chk("ch1_disabled_en", {31'b0, en_out[1]}, 32'd0);
    write(1, 3, 1);
    tick(1);
    chk("ch1_div3_ready", {31'b0, cfg_ready}, 32'd1);
    chk("ch1_div3_cnt1_clk", {31'b0, clk_out[1]}, 32'd1);
    tick(1);
    chk("ch1_div3_cnt2_clk", {31'b0, clk_out[1]}, 32'd0);
    wait_locked(40);

    write(0, 5, 9);
    wait_ready(20);
    chk("ch0_phase_clamp_clk", {31'b0, clk_out[0]}, 32'd1);
    wait_locked(40);

    write(3, 7, 2);
    chk("badch_ready_low", {31'b0, cfg_ready}, 32'd0);
    tick(1);
    chk("badch_ready_back", {31'b0, cfg_ready}, 32'd1);
    chk("badch_locked_kept", {31'b0, locked}, 32'd1);

    write(0, 2, 1);
    write(1, 4, 0);
    wait_ready(20);
    k = 0;
    while (!locked && k < 100) begin
      tick(1);
      k++;
    end
    chk("relock_after_last_apply", k, 32'd16);

    write(2, 7, 3);
    rst = 1'b1;
    tick(1);
    chk("rst_pend_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_pend_locked", {31'b0, locked}, 32'd0);
    chk("rst_pend_clk_out", {29'b0, clk_out}, 32'd7);
    rst = 1'b0;
    tick(2);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      hi += int'(clk_out[2]);
      tick(1);
    end
    chk("ch2_default_after_rst", hi, 32'd6);
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
